// File: rtl/eggo_io_pkg.sv
// eggo_io_pkg: constants and helpers shared by the stack-core IO bridge.
//   IO_WIDTH          default width of every IO word
//   OUT_DEPTH_DEFAULT default output FIFO depth (power of two, >= 2)
//   fifo_ptr_width()  pointer width for a FIFO of a given depth; the
//                     extra MSB tells a full FIFO apart from an empty one
package eggo_io_pkg;

    localparam int unsigned IO_WIDTH          = 16;
    localparam int unsigned OUT_DEPTH_DEFAULT = 4;

    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if: groups the core-side and external-side handshake
// signals of io_port_bridge.
//   master modport : the bridge itself (drives out_full, ext_out_*,
//                    ext_in_ready, cpu_in_data, in_avail, err_*)
//   slave modport  : the surrounding core / external agents
interface io_port_bridge_if
    import eggo_io_pkg::*;
#(
    parameter int unsigned WIDTH = IO_WIDTH
);
    logic [WIDTH-1:0] cpu_out_data;
    logic             cpu_out_we;
    logic             out_full;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [WIDTH-1:0] cpu_in_data;
    logic             in_avail;
    logic             cpu_in_re;
    logic             err_drop;
    logic             err_empty;
    logic             err_clr;

    modport master (
        input  cpu_out_data, cpu_out_we, ext_out_ready,
        input  ext_in_data, ext_in_valid, cpu_in_re, err_clr,
        output out_full, ext_out_data, ext_out_valid, ext_in_ready,
        output cpu_in_data, in_avail, err_drop, err_empty
    );

    modport slave (
        output cpu_out_data, cpu_out_we, ext_out_ready,
        output ext_in_data, ext_in_valid, cpu_in_re, err_clr,
        input  out_full, ext_out_data, ext_out_valid, ext_in_ready,
        input  cpu_in_data, in_avail, err_drop, err_empty
    );
endinterface

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n  clock, asynchronous active-low reset (clears memory too)
//   push_i      write wdata_i; accepted when not full, or full with a pop
//   pop_i       consume the head word; ignored when empty
//   rdata_o     head word (valid while empty_o is low)
//   full_o, empty_o, count_o  occupancy status
module io_sync_fifo
    import eggo_io_pkg::*;
#(
    parameter int unsigned WIDTH = IO_WIDTH,
    parameter int unsigned DEPTH = OUT_DEPTH_DEFAULT,
    localparam int unsigned PW   = fifo_ptr_width(DEPTH),
    localparam int unsigned IW   = PW - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Same index with differing wrap bit means the writer is a lap ahead.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[IW-1:0]];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) mem_q[wr_ptr_q[IW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: IO bridge between the stack core and the outside world.
//   clk    system clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    io_port_bridge_if.master:
//     downstream: cpu_out_data/cpu_out_we -> output FIFO -> ext_out_*
//     upstream  : ext_in_* -> one-word holding register -> cpu_in_data,
//                 in_avail, consumed by cpu_in_re
//     sticky err_drop / err_empty, cleared by err_clr (set wins)
module io_port_bridge
    import eggo_io_pkg::*;
#(
    parameter int unsigned WIDTH     = IO_WIDTH,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEFAULT,
    localparam int unsigned PW       = fifo_ptr_width(OUT_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    io_port_bridge_if.master  bus
);

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [PW-1:0]    fifo_count;
    logic [WIDTH-1:0] fifo_rdata;

    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic             in_avail_q, in_avail_d;
    logic             err_drop_q, err_drop_d;
    logic             err_empty_q, err_empty_d;
    logic             in_accept, drop_evt, empty_evt;

    assign fifo_pop = !fifo_empty && bus.ext_out_ready;

    io_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (bus.cpu_out_we),
        .pop_i   (fifo_pop),
        .wdata_i (bus.cpu_out_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.out_full      = fifo_full;
    assign bus.ext_out_valid = !fifo_empty;
    assign bus.ext_out_data  = fifo_rdata;

    // A read in the same cycle frees the holding register for a new word.
    assign bus.ext_in_ready = !in_avail_q || bus.cpu_in_re;
    assign in_accept        = bus.ext_in_valid && bus.ext_in_ready;

    assign drop_evt  = bus.cpu_out_we && (fifo_count == PW'(OUT_DEPTH)) && !fifo_pop;
    assign empty_evt = bus.cpu_in_re && !in_avail_q;

    always_comb begin
        in_data_d   = in_data_q;
        in_avail_d  = in_avail_q;
        err_drop_d  = err_drop_q;
        err_empty_d = err_empty_q;

        if (in_accept) begin
            in_data_d  = bus.ext_in_data;
            in_avail_d = 1'b1;
        end else if (bus.cpu_in_re) begin
            in_avail_d = 1'b0;
        end

        if (bus.err_clr) begin
            err_drop_d  = 1'b0;
            err_empty_d = 1'b0;
        end
        if (drop_evt)  err_drop_d  = 1'b1;
        if (empty_evt) err_empty_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_data_q   <= '0;
            in_avail_q  <= 1'b0;
            err_drop_q  <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            in_data_q   <= in_data_d;
            in_avail_q  <= in_avail_d;
            err_drop_q  <= err_drop_d;
            err_empty_q <= err_empty_d;
        end
    end

    assign bus.cpu_in_data = in_data_q;
    assign bus.in_avail    = in_avail_q;
    assign bus.err_drop    = err_drop_q;
    assign bus.err_empty   = err_empty_q;

endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;
    import eggo_io_pkg::*;

    localparam int unsigned W = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] out_sb[$];

    io_port_bridge_if #(.WIDTH(W)) bus ();

    io_port_bridge #(
        .WIDTH     (W),
        .OUT_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] w, input bit expect_accept);
        bus.cpu_out_data = w;
        bus.cpu_out_we   = 1'b1;
        if (expect_accept) out_sb.push_back(w);
        tick();
        bus.cpu_out_we   = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        logic [W-1:0] exp;
        bus.ext_out_ready = 1'b1;
        #1;
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (bus.ext_out_valid !== 1'b1 || out_sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s_valid[%0d]: got %b expected 1 (sb %0d)", name, k, bus.ext_out_valid, out_sb.size());
            end else begin
                exp = out_sb.pop_front();
                if (bus.ext_out_data !== exp) begin
                    n_fail++;
                    $display("FAIL %s_data[%0d]: got %h expected %h", name, k, bus.ext_out_data, exp);
                end
            end
            tick();
        end
        bus.ext_out_ready = 1'b0;
        n_checks++;
        if (bus.ext_out_valid !== 1'b0 || out_sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_empty: got valid %b sb %0d expected 0 0", name, bus.ext_out_valid, out_sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cpu_out_we   = 1'b1;
        bus.cpu_out_data = 16'hABCD;
        repeat (4) tick();
        n_checks++;
        if ({bus.ext_out_valid, bus.ext_out_data, bus.out_full, bus.cpu_in_data,
             bus.in_avail, bus.err_drop, bus.err_empty} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b d%h f%b in%h a%b ed%b ee%b expected all 0",
                     bus.ext_out_valid, bus.ext_out_data, bus.out_full, bus.cpu_in_data,
                     bus.in_avail, bus.err_drop, bus.err_empty);
        end
        bus.cpu_out_we = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.ext_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.ext_in_ready);
        end
        tick();
        n_checks++;
        if (bus.ext_out_valid !== 1'b0 || bus.out_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_entries: got valid %b full %b expected 0 0", bus.ext_out_valid, bus.out_full);
        end
    endtask

    task automatic test_buffered_drain();
        write_word(16'h0008, 1'b1);
        n_checks++;
        if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'h0008) begin
            n_fail++;
            $display("FAIL drain_latency: got valid %b data %h expected 1 0008", bus.ext_out_valid, bus.ext_out_data);
        end
        write_word(16'h0011, 1'b1);
        write_word(16'h0019, 1'b1);
        tick();
        n_checks++;
        if (bus.ext_out_data !== 16'h0008 || bus.out_full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_hold: got data %h full %b expected 0008 0", bus.ext_out_data, bus.out_full);
        end
        drain("drain", 3);
    endtask

    task automatic test_empty_push_pop();
        bus.cpu_out_data  = 16'h0077;
        bus.cpu_out_we    = 1'b1;
        bus.ext_out_ready = 1'b1;
        out_sb.push_back(16'h0077);
        tick();
        bus.cpu_out_we    = 1'b0;
        bus.ext_out_ready = 1'b0;
        n_checks++;
        if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'h0077) begin
            n_fail++;
            $display("FAIL empty_push_pop: got valid %b data %h expected 1 0077", bus.ext_out_valid, bus.ext_out_data);
        end
        drain("empty_pp", 1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 3; i++) write_word(W'(i), 1'b1);
        n_checks++;
        if (bus.out_full !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_not_full: got %b expected 0", bus.out_full);
        end
        write_word(16'd4, 1'b1);
        n_checks++;
        if (bus.out_full !== 1'b1 || bus.err_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got full %b drop %b expected 1 0", bus.out_full, bus.err_drop);
        end
        write_word(16'd5, 1'b0);
        n_checks++;
        if (bus.err_drop !== 1'b1 || bus.out_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got drop %b full %b expected 1 1", bus.err_drop, bus.out_full);
        end
        drain("ovf", 4);
        n_checks++;
        if (bus.err_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", bus.err_drop);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.err_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b expected 0", bus.err_drop);
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp;
        for (int i = 1; i <= 4; i++) write_word(W'(i), 1'b1);
        bus.cpu_out_data  = 16'd9;
        bus.cpu_out_we    = 1'b1;
        bus.ext_out_ready = 1'b1;
        #1;
        exp = out_sb.pop_front();
        n_checks++;
        if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== exp) begin
            n_fail++;
            $display("FAIL fpp_pop: got valid %b data %h expected 1 %h", bus.ext_out_valid, bus.ext_out_data, exp);
        end
        out_sb.push_back(16'd9);
        tick();
        bus.cpu_out_we    = 1'b0;
        bus.ext_out_ready = 1'b0;
        n_checks++;
        if (bus.out_full !== 1'b1 || bus.err_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_state: got full %b drop %b expected 1 0", bus.out_full, bus.err_drop);
        end
        drain("fpp", 4);
    endtask

    task automatic test_input_path();
        bus.ext_in_data  = 16'd5040;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_in_data !== 16'd5040 || bus.in_avail !== 1'b1 || bus.ext_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_load: got data %0d avail %b ready %b expected 5040 1 0",
                     bus.cpu_in_data, bus.in_avail, bus.ext_in_ready);
        end
        bus.cpu_in_re    = 1'b1;
        bus.ext_in_data  = 16'd42;
        bus.ext_in_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.ext_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_re: got %b expected 1", bus.ext_in_ready);
        end
        tick();
        bus.cpu_in_re    = 1'b0;
        bus.ext_in_valid = 1'b0;
        n_checks++;
        if (bus.cpu_in_data !== 16'd42 || bus.in_avail !== 1'b1) begin
            n_fail++;
            $display("FAIL in_reload: got data %0d avail %b expected 42 1", bus.cpu_in_data, bus.in_avail);
        end
        bus.cpu_in_re = 1'b1;
        tick();
        bus.cpu_in_re = 1'b0;
        n_checks++;
        if (bus.in_avail !== 1'b0 || bus.cpu_in_data !== 16'd42 || bus.err_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL in_consume: got avail %b data %0d err %b expected 0 42 0",
                     bus.in_avail, bus.cpu_in_data, bus.err_empty);
        end
    endtask

    task automatic test_empty_read_reset();
        bus.cpu_in_re = 1'b1;
        tick();
        bus.cpu_in_re = 1'b0;
        n_checks++;
        if (bus.err_empty !== 1'b1 || bus.cpu_in_data !== 16'd42 || bus.in_avail !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read: got err %b data %0d avail %b expected 1 42 0",
                     bus.err_empty, bus.cpu_in_data, bus.in_avail);
        end
        bus.cpu_in_re = 1'b1;
        bus.err_clr   = 1'b1;
        tick();
        bus.cpu_in_re = 1'b0;
        bus.err_clr   = 1'b0;
        n_checks++;
        if (bus.err_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got %b expected 1", bus.err_empty);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.err_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_clr: got %b expected 0", bus.err_empty);
        end
        write_word(16'h00A1, 1'b1);
        write_word(16'h00A2, 1'b1);
        bus.ext_in_data  = 16'h1234;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        #2;
        reset = 1'b0;
        out_sb.delete();
        #1;
        n_checks++;
        if (bus.ext_out_valid !== 1'b0 || bus.cpu_in_data !== '0 || bus.in_avail !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got valid %b data %h avail %b expected 0 0000 0",
                     bus.ext_out_valid, bus.cpu_in_data, bus.in_avail);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.ext_out_valid !== 1'b0 || bus.ext_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got valid %b ready %b expected 0 1", bus.ext_out_valid, bus.ext_in_ready);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.cpu_out_data  = '0;
        bus.cpu_out_we    = 1'b0;
        bus.ext_out_ready = 1'b0;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.cpu_in_re     = 1'b0;
        bus.err_clr       = 1'b0;
        test_reset();
        test_buffered_drain();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_input_path();
        test_empty_read_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Sits between the stack processor core (datapathCONTROL_eggo) and the outside world.
- Downstream: buffers the core's output_IO writes in a small FIFO and drains them over a valid/ready handshake.
- Upstream: captures one external input word through a valid/ready handshake and presents it to the core's input_IO.
- Sticky error flags record dropped writes and empty reads.

Parameters:
- WIDTH, 16, data width of all IO words.
- OUT_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_out_data  in  WIDTH  word written by the core (core's output_IO).
- cpu_out_we  in  1  one-cycle write strobe from the core.
- out_full  out  1  output FIFO holds OUT_DEPTH entries.
- ext_out_data  out  WIDTH  FIFO head word.
- ext_out_valid  out  1  FIFO not empty.
- ext_out_ready  in  1  external consumer accepts the head word.
- ext_in_data  in  WIDTH  word from the external producer.
- ext_in_valid  in  1  external producer offers ext_in_data.
- ext_in_ready  out  1  bridge can accept an input word.
- cpu_in_data  out  WIDTH  held input word (drives the core's input_IO).
- in_avail  out  1  cpu_in_data holds an unread word.
- cpu_in_re  in  1  one-cycle read strobe from the core.
- err_drop  out  1  sticky: a write was dropped because the FIFO was full.
- err_empty  out  1  sticky: a read was issued with in_avail low.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-safe deassert):
  - FIFO pointers, count and memory cleared.
  - Outputs: ext_out_valid=0, ext_out_data=0, out_full=0, cpu_in_data=0, in_avail=0, err_drop=0, err_empty=0.
  - ext_in_ready=1 once reset deasserts.
  - Reset mid-transfer discards all buffered data; no partial handshakes.
- Output FIFO (first-word fall-through):
  - Push when cpu_out_we=1 and (out_full=0 or a pop occurs in the same cycle).
  - Pop when ext_out_valid=1 and ext_out_ready=1.
  - Write at edge N: ext_out_valid=1 and ext_out_data=word during cycle N+1.
  - Empty FIFO with simultaneous push and ext_out_ready=1: no pop; the word appears next cycle.
  - Full FIFO with simultaneous push and pop: both accepted; count stays OUT_DEPTH.
  - Full FIFO with push and no pop: word dropped, err_drop set at the next edge, FIFO contents unchanged.
  - Pointers are log2(OUT_DEPTH)+1 bits and wrap modulo 2*OUT_DEPTH; full/empty decided by comparing the MSB and the remaining bits.
  - ext_out_data is stable while ext_out_valid=1 and ext_out_ready=0.
- Input holding register:
  - ext_in_ready = !in_avail | cpu_in_re (combinational).
  - Accept when ext_in_valid & ext_in_ready: cpu_in_data<=ext_in_data and in_avail<=1 at that edge.
  - cpu_in_re with in_avail=1 and no accept: in_avail<=0; cpu_in_data holds its last value.
  - cpu_in_re and accept in the same cycle: new word loaded, in_avail stays 1.
  - cpu_in_re with in_avail=0: no data change; err_empty set.
- Sticky flags:
  - Set only by their error events; cleared by err_clr.
  - err_clr together with a new error event in the same cycle: the flag is set (set wins).
- Latency: 1 cycle from either handshake edge to visibility on the opposite side; no combinational path from ext_in_data to ext_out_data.

Decomposition:
- Shared package eggo_io_pkg: IO_WIDTH=16 and OUT_DEPTH_DEFAULT=4, plus a function computing the FIFO pointer width.
- One sub-module: io_sync_fifo, the parameterised FWFT FIFO with push, pop, full, empty and count.
- io_port_bridge instantiates io_sync_fifo and adds the input register and the error logic.

Test Plan:
- Reset: hold reset=0 for 4 cycles with cpu_out_we=1 -> all outputs 0, ext_in_ready=1, no FIFO entries after release.
- Buffered drain: write 0x0008, 0x0011, 0x0019 with ext_out_ready=0, then raise ready -> ext_out_valid held high, words emerge in order on 3 consecutive cycles, then valid=0.
- Overflow: 5 writes (1..5) with ready=0 -> out_full=1 after the 4th; 5 dropped; err_drop=1; drain yields 1,2,3,4 only; err_clr -> err_drop=0.
- Full push+pop: FIFO full (1..4), write 9 with ready=1 -> 1 popped, 9 accepted, out_full stays 1, drain yields 2,3,4,9, err_drop=0.
- Input path: ext_in_data=5040 with valid=1 -> next cycle cpu_in_data=5040, in_avail=1, ext_in_ready=0; then cpu_in_re with ext_in_data=42 valid -> cpu_in_data=42, in_avail=1.
- Empty read and mid-op reset: cpu_in_re with in_avail=0 -> err_empty=1, cpu_in_data unchanged; reset pulsed with 2 FIFO entries -> ext_out_valid=0 immediately, cpu_in_data=0.
